// File: rtl/fpu_issue.sv
// rtl/fpu_issue.sv - FPU front-end sequencer launching add/mul/div units
module fpu_issue #(
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [5:0]  cmd,
    input  logic [30:0] opa,
    input  logic [30:0] opb,
    output logic        ready,
    output logic        done,
    output logic [30:0] res,
    output logic        ovf,
    output logic        err,
    output logic [30:0] u_in1,
    output logic [30:0] u_in2,
    output logic        add_start,
    output logic        mul_start,
    output logic        div_start,
    input  logic        add_stop,
    input  logic        mul_stop,
    input  logic        div_stop,
    input  logic [30:0] add_out,
    input  logic [30:0] mul_out,
    input  logic [30:0] div_out,
    input  logic        add_ovf,
    input  logic        mul_ovf,
    input  logic        div_ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Last WAIT cycle: the counter starts at 0 in the first WAIT cycle,
    // so TIMEOUT WAIT cycles have elapsed when it shows TIMEOUT-1.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [5:0]  cmd_r;
    logic [7:0]  cnt;
    logic        accept;
    logic        legal;
    logic        div_zero;
    logic        timeout_hit;
    logic        sel_stop;
    logic [30:0] sel_out;
    logic        sel_ovf;

    assign ready = (state == S_IDLE);

    // Route the stop/result/overflow of the unit selected by the latched command
    always_comb begin
        sel_stop = 1'b0;
        sel_out  = '0;
        sel_ovf  = 1'b0;
        case (cmd_r)
            6'd1, 6'd2: begin
                sel_stop = add_stop;
                sel_out  = add_out;
                sel_ovf  = add_ovf;
            end
            6'd3: begin
                sel_stop = mul_stop;
                sel_out  = mul_out;
                sel_ovf  = mul_ovf;
            end
            6'd4: begin
                sel_stop = div_stop;
                sel_out  = div_out;
                sel_ovf  = div_ovf;
            end
            default: ;
        endcase
    end

    // Next-state decode; commands that need no unit go straight to DONE
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        legal       = (cmd >= 6'd1) && (cmd <= 6'd4);
        div_zero    = (cmd == 6'd4) && (opb[23:0] == 24'd0);
        timeout_hit = (cnt == CNT_LAST);
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    state_next = (legal && !div_zero) ? S_START : S_DONE;
                end
            end
            S_START: state_next = S_WAIT;
            S_WAIT: begin
                if (sel_stop || timeout_hit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, start pulses, wait counter and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r     <= '0;
            u_in1     <= '0;
            u_in2     <= '0;
            res       <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
            add_start <= 1'b0;
            mul_start <= 1'b0;
            div_start <= 1'b0;
            cnt       <= '0;
        end else begin
            add_start <= 1'b0;
            mul_start <= 1'b0;
            div_start <= 1'b0;
            done      <= 1'b0;

            if (accept) begin
                cmd_r <= cmd;
                u_in1 <= opa;
                u_in2 <= (cmd == 6'd2) ? {~opb[30], opb[29:0]} : opb;
                res   <= '0;
                ovf   <= 1'b0;
                err   <= 1'b0;
                if (!legal) begin
                    err  <= 1'b1;
                    done <= 1'b1;
                end else if (div_zero) begin
                    res  <= opa;
                    ovf  <= 1'b1;
                    done <= 1'b1;
                end else begin
                    add_start <= (cmd == 6'd1) || (cmd == 6'd2);
                    mul_start <= (cmd == 6'd3);
                    div_start <= (cmd == 6'd4);
                end
            end

            if (state == S_START) begin
                cnt <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + 8'd1;
            end

            // A stop in the timeout cycle takes precedence over the abort
            if (state == S_WAIT) begin
                if (sel_stop) begin
                    res  <= sel_out;
                    ovf  <= sel_ovf;
                    done <= 1'b1;
                end else if (timeout_hit) begin
                    res  <= '0;
                    ovf  <= 1'b0;
                    err  <= 1'b1;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue.sv
// tb/tb_fpu_issue.sv - self-checking bench for fpu_issue with unit stubs
module tb_fpu_issue;

    localparam int TO = 63;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [5:0]  cmd;
    logic [30:0] opa;
    logic [30:0] opb;
    logic        ready;
    logic        done;
    logic [30:0] res;
    logic        ovf;
    logic        err;
    logic [30:0] u_in1;
    logic [30:0] u_in2;
    logic        add_start;
    logic        mul_start;
    logic        div_start;
    logic        add_stop;
    logic        mul_stop;
    logic        div_stop;
    logic [30:0] add_out;
    logic [30:0] mul_out;
    logic [30:0] div_out;
    logic        add_ovf;
    logic        mul_ovf;
    logic        div_ovf;

    int vectors = 0;
    int miscompares = 0;

    // Unit stub state, index 0=add, 1=mul, 2=div
    int          lat[3];
    bit          hang[3];
    bit          hang_c[3];
    bit          busy[3];
    bit          need2[3];
    int          rem[3];
    logic [30:0] cap1[3];
    logic [30:0] cap2[3];
    logic        stop_s[3];
    logic [30:0] out_s[3];
    logic        ovf_s[3];
    logic        stray_add;

    fpu_issue #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .opa(opa), .opb(opb),
        .ready(ready), .done(done), .res(res), .ovf(ovf), .err(err),
        .u_in1(u_in1), .u_in2(u_in2),
        .add_start(add_start), .mul_start(mul_start), .div_start(div_start),
        .add_stop(add_stop), .mul_stop(mul_stop), .div_stop(div_stop),
        .add_out(add_out), .mul_out(mul_out), .div_out(div_out),
        .add_ovf(add_ovf), .mul_ovf(mul_ovf), .div_ovf(div_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign add_stop = stop_s[0] | stray_add;
    assign mul_stop = stop_s[1];
    assign div_stop = stop_s[2];
    assign add_out  = out_s[0];
    assign mul_out  = out_s[1];
    assign div_out  = out_s[2];
    assign add_ovf  = ovf_s[0];
    assign mul_ovf  = ovf_s[1];
    assign div_ovf  = ovf_s[2];

    function automatic logic [30:0] stub_res(input int u, input logic [30:0] x, input logic [30:0] y);
        if (u == 0) return y;
        if (u == 1) return {x[30] ^ y[30], y[29:0]};
        return x ^ y;
    endfunction

    function automatic logic stub_ovf(input int u, input logic [30:0] x, input logic [30:0] y);
        if (u == 0) return x[1] & y[1];
        if (u == 1) return x[0] & y[0];
        return x[2] ^ y[2];
    endfunction

    // Unit stubs: in1 taken in the start cycle, in2 one cycle later, stop after lat cycles
    always @(negedge clk) begin
        logic [2:0] st;
        st = {div_start, mul_start, add_start};
        for (int u = 0; u < 3; u++) begin
            stop_s[u] = 1'b0;
            if (busy[u]) begin
                if (need2[u]) begin
                    cap2[u]  = u_in2;
                    need2[u] = 1'b0;
                end
                if (!hang_c[u]) begin
                    rem[u] = rem[u] - 1;
                    if (rem[u] == 0) begin
                        stop_s[u] = 1'b1;
                        out_s[u]  = stub_res(u, cap1[u], cap2[u]);
                        ovf_s[u]  = stub_ovf(u, cap1[u], cap2[u]);
                        busy[u]   = 1'b0;
                    end
                end
            end
            if (st[u]) begin
                cap1[u]   = u_in1;
                need2[u]  = 1'b1;
                busy[u]   = 1'b1;
                rem[u]    = lat[u];
                hang_c[u] = hang[u];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: what the sequencer must report for one command
    task automatic model(input logic [5:0] c, input logic [30:0] a, input logic [30:0] b,
                         output logic [30:0] beff, output logic [30:0] eres,
                         output logic eovf, output logic eerr, output int edone, output int eunit);
        beff = (c == 6'd2) ? (b ^ 31'h40000000) : b;
        eres = '0; eovf = 1'b0; eerr = 1'b0;
        case (c)
            6'd1, 6'd2: eunit = 0;
            6'd3:       eunit = 1;
            6'd4:       eunit = 2;
            default:    eunit = -1;
        endcase
        if (eunit < 0) begin
            eerr = 1'b1; edone = 1;
        end else if (c == 6'd4 && b[23:0] == 24'd0) begin
            eunit = -1; eres = a; eovf = 1'b1; edone = 1;
        end else if (hang[eunit] || lat[eunit] > TO) begin
            eerr = 1'b1; edone = TO + 2;
        end else begin
            eres  = stub_res(eunit, a, beff);
            eovf  = stub_ovf(eunit, a, beff);
            edone = 2 + lat[eunit];
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300 && ready !== 1'b1; i++) @(negedge clk);
        chk("ready_wait", 32'(ready), 32'd1);
    endtask

    task automatic run_cmd(input logic [5:0] c, input logic [30:0] a, input logic [30:0] b, input int stray_cyc);
        logic [30:0] beff, eres, res_d;
        logic        eovf, eerr;
        int          edone, eunit, cyc, done_cyc, start_cyc;
        int          nstart[3];
        bit          bus_ok;
        model(c, a, b, beff, eres, eovf, eerr, edone, eunit);
        wait_ready();
        req = 1'b1; cmd = c; opa = a; opb = b;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; cmd = 6'($urandom); opa = 31'($urandom); opb = 31'($urandom);
        cyc = 1; done_cyc = -1; start_cyc = -1; bus_ok = 1'b1;
        nstart[0] = 0; nstart[1] = 0; nstart[2] = 0;
        while (cyc < 200) begin
            if (add_start) begin nstart[0]++; start_cyc = cyc; end
            if (mul_start) begin nstart[1]++; start_cyc = cyc; end
            if (div_start) begin nstart[2]++; start_cyc = cyc; end
            if (u_in1 !== a || u_in2 !== beff) bus_ok = 1'b0;
            if (done === 1'b1) begin done_cyc = cyc; break; end
            @(negedge clk);
            cyc++;
            stray_add = (cyc == stray_cyc);
        end
        stray_add = 1'b0;
        chk("done_cycle", 32'(done_cyc), 32'(edone));
        chk("res", 32'(res), 32'(eres));
        chk("ovf", 32'(ovf), 32'(eovf));
        chk("err", 32'(err), 32'(eerr));
        chk("bus_stable", 32'(bus_ok), 32'd1);
        for (int u = 0; u < 3; u++) chk("start_count", 32'(nstart[u]), 32'(u == eunit));
        if (eunit >= 0) begin
            chk("start_cycle", 32'(start_cyc), 32'd1);
            chk("unit_in1", 32'(cap1[eunit]), 32'(a));
            chk("unit_in2", 32'(cap2[eunit]), 32'(beff));
        end
        res_d = res;
        @(negedge clk);
        chk("done_pulse", {30'd0, done, ready}, 32'd1);
        chk("res_held", 32'(res), 32'(eres));
    endtask

    initial begin
        int nst, ndone, nother;
        bit seen_done;
        logic [5:0]  rc;
        logic [30:0] ra, rb;
        rst_n = 1'b0; req = 1'b0; cmd = '0; opa = '0; opb = '0; stray_add = 1'b0;
        for (int u = 0; u < 3; u++) begin
            lat[u] = 4; hang[u] = 1'b0; stop_s[u] = 1'b0; out_s[u] = '0; ovf_s[u] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_flags", {26'd0, done, ovf, err, add_start, mul_start, div_start}, 32'd0);
        chk("reset_res", 32'(res), 32'd0);
        chk("reset_bus", {1'b0, u_in1 | u_in2}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // FMUL 1.0 x 2.0 with a stray add_stop during WAIT
        lat[1] = 7;
        run_cmd(6'd3, 31'h21040000, 31'h21080000, 4);
        chk("fmul_res", 32'(res), 32'h21080000);

        // FSUB: add stub echoes in2, sign of opb flipped
        lat[0] = 5;
        run_cmd(6'd2, 31'h1234567, 31'h21080000, 0);
        chk("fsub_res", 32'(res), 32'h61080000);

        // FDIV with zero fraction, then illegal command
        run_cmd(6'd4, 31'h2A0F0F0F, 31'h45000000, 0);
        run_cmd(6'd7, 31'h11111111, 31'h22222222, 0);

        // Hung multiplier times out
        hang[1] = 1'b1;
        run_cmd(6'd3, 31'h0ABCDEF0, 31'h13572468, 0);
        hang[1] = 1'b0;

        // Stop in the last WAIT cycle wins; one cycle later loses to timeout
        lat[2] = TO;
        run_cmd(6'd4, 31'h300000FF, 31'h10000001, 0);
        lat[0] = TO + 1;
        run_cmd(6'd1, 31'h0000AAAA, 31'h00005555, 0);

        // req held high: accepts only when ready, one start each
        lat[0] = 3;
        wait_ready();
        req = 1'b1; cmd = 6'd1; opa = 31'h01020304; opb = 31'h05060708;
        nst = 0; ndone = 0; nother = 0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (add_start) nst++;
            if (mul_start || div_start) nother++;
            if (done) ndone++;
            if (k == 36) req = 1'b0;
        end
        chk("b2b_starts", 32'(nst), 32'd6);
        chk("b2b_dones", 32'(ndone), 32'd6);
        chk("b2b_other", 32'(nother), 32'd0);

        // Reset during an FMUL WAIT
        lat[1] = 7;
        wait_ready();
        req = 1'b1; cmd = 6'd3; opa = 31'h7FFFFFFF; opb = 31'h2AAAAAAA;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_flags", {26'd0, done, ovf, err, add_start, mul_start, div_start}, 32'd0);
        chk("mid_rst_res", 32'(res), 32'd0);
        chk("mid_rst_bus", {1'b0, u_in1 | u_in2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("post_rst_no_done", 32'(seen_done), 32'd0);
        run_cmd(6'd3, 31'h21040000, 31'h21080000, 0);

        // Randomized commands against the reference model
        for (int n = 0; n < 30; n++) begin
            for (int u = 0; u < 3; u++) begin
                lat[u]  = $urandom_range(1, 12);
                hang[u] = ($urandom_range(0, 14) == 0);
            end
            case ($urandom_range(0, 5))
                0: rc = 6'd1;
                1: rc = 6'd2;
                2: rc = 6'd3;
                3: rc = 6'd4;
                default: rc = 6'($urandom);
            endcase
            ra = 31'($urandom);
            rb = 31'($urandom);
            if (rc == 6'd4 && $urandom_range(0, 2) == 0) rb[23:0] = 24'd0;
            run_cmd(rc, ra, rb, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fpu_issue.md
# fpu_issue

Front-end sequencer of the floating-point unit. It accepts one floating-point command (FADD, FSUB, FMUL, FDIV) with two MIX-format operands and launches the matching arithmetic unit with that unit's start/in1/in2 protocol. It waits for the unit's stop pulse, then registers the result and flags for the CPU. It also handles illegal commands, zero divisors and hung units without launching or waiting indefinitely.

## Interface
Parameters:
- TIMEOUT, 63: maximum WAIT cycles before the command is aborted with err (range 8–255).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  command request; accepted only when ready=1.
- cmd  in  6  F-field: 1=FADD, 2=FSUB, 3=FMUL, 4=FDIV; other values are illegal.
- opa  in  31  rA operand {sign, exp[5:0], frac[23:0]}.
- opb  in  31  memory operand, same format.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse; res/ovf/err are valid in that cycle and held until the next accept.
- res  out  31  result word.
- ovf  out  1  overflow (unit overflow or divide by zero).
- err  out  1  illegal cmd or timeout.
- u_in1  out  31  operand 1 bus shared by all units.
- u_in2  out  31  operand 2 bus shared by all units; sign inverted for FSUB.
- add_start, mul_start, div_start  out  1 each  start pulses; FADD and FSUB both use add_start.
- add_stop, mul_stop, div_stop  in  1 each  unit completion pulses.
- add_out, mul_out, div_out  in  31 each  unit results, sampled in the stop cycle.
- add_ovf, mul_ovf, div_ovf  in  1 each  unit overflow flags, sampled in the stop cycle.

## Operation
- States: IDLE, START, WAIT, DONE (2-bit register).
- Reset values: state=IDLE; ready=1; done=0, res=0, ovf=0, err=0; all *_start=0; u_in1=0, u_in2=0; timeout counter=0.
- IDLE with req=1:
  - Capture cmd and opa into opa_r.
  - Capture opb into opb_r; for cmd=2, bit 30 is inverted.
  - Clear res, ovf and err.
  - cmd in {1,2,3}, or cmd=4 with opb frac≠0 → START.
  - cmd=4 with opb[23:0]=0 → DONE; res=opa, ovf=1, err=0; no start pulse is issued.
  - Illegal cmd → DONE; res=0, err=1, ovf=0; no start pulse is issued.
- u_in1=opa_r and u_in2=opb_r continuously from the accept edge onward; both stay stable through START and WAIT.
  - Units sample in1 in their start cycle and in2 in the following cycle; both are satisfied because the buses do not change.
- START (exactly one cycle):
  - Exactly one *_start is high, selected by cmd_r.
  - Timeout counter cleared.
  - → WAIT.
- WAIT:
  - The counter increments each cycle.
  - Selected unit's stop=1: register that unit's out into res and its ovf into ovf → DONE.
  - Counter reaches TIMEOUT without stop: res=0, ovf=0, err=1 → DONE.
  - Stop wins if it arrives in the same cycle the counter reaches TIMEOUT.
- DONE: done=1 for one cycle → IDLE. req is ignored in DONE.
- Stop pulses from non-selected units, and any stop seen in IDLE, START or DONE, are ignored.
- req while ready=0 is dropped; nothing is queued.
- rst_n low at any time forces the reset values immediately. A stop arriving after rst_n releases is ignored because the state is IDLE.

## Timing
- Request sampled at edge 0 → START during cycle 1, with mul_start high.
- FMUL stop asserts 7 cycles after its start cycle, in cycle 8 → done in cycle 9.
- Accept-to-done latency = 2 + (unit latency), where unit latency is start-to-stop.
- Illegal cmd / divide-by-zero: done in cycle 1.
- Timeout: done in cycle TIMEOUT+2.
- Earliest next accept: the cycle after done (ready=1 again).
- All outputs are registered except ready, which is decoded from the state.

## Test plan
- FMUL, 1.0×2.0: opa=31'h21040000, opb=31'h21080000, cmd=3 with the real multiplier attached → mul_start only in cycle 1; done in cycle 9; res=31'h21080000, ovf=0, err=0.
- FSUB: opb=31'h21080000, cmd=2, FADD stub echoes in2 → add_start pulses; u_in2=31'h61080000 held stable from START to stop; res=31'h61080000.
- FDIV, zero divisor: opb frac=0, cmd=4 → no start pulse; done in cycle 1; res=opa, ovf=1, err=0.
- Illegal cmd=7, then timeout: stub that never stops, TIMEOUT=63 →
  - cmd=7: done in cycle 1, err=1.
  - Hung unit: done in cycle 65, err=1, res=0.
- Back-to-back / stray stop:
  - req held high continuously → commands accepted only when ready=1; exactly one start per accept.
  - add_stop pulsed during an FMUL WAIT → ignored.
- Reset mid-WAIT: rst_n low in cycle 4 of an FMUL → all outputs at reset values immediately. The unit's later stop produces no done; a new req afterwards completes normally.
